// File: rtl/alu_sequencer_if.sv
// Memory-side handshakes of the sequencer: instruction fetch port and data-memory port.
// Handshake rule: a request stays high until its ack; an ack counts only in a cycle where its request is high.
interface alu_sequencer_if;
   logic       imem_req;
   logic       imem_ack;
   logic [8:0] instr_in;
   logic       dmem_req;
   logic       dmem_we;
   logic       dmem_wsel;
   logic       dmem_ack;

   modport master (
      output imem_req,
      input  imem_ack,
      input  instr_in,
      output dmem_req,
      output dmem_we,
      output dmem_wsel,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      output imem_ack,
      output instr_in,
      input  dmem_req,
      input  dmem_we,
      input  dmem_wsel,
      output dmem_ack
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for the 8-bit ALU datapath.
// Owns the PC, the instruction register, the latched less-than flag and the sign-mode bit.
module alu_sequencer #(
   parameter logic [7:0] PC_RESET      = 8'h00,
   parameter logic       SIGN_MODE_DEF = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   alu_sequencer_if.master bus,
   output logic [7:0]      pc,
   output logic [3:0]      alu_opcode,
   output logic            alu_sign,
   output logic            alu_b_imm,
   output logic [7:0]      alu_imm,
   input  logic            alu_lt,
   input  logic            alu_ovf,
   output logic [2:0]      rf_ra,
   output logic [2:0]      rf_rb,
   output logic            rf_we,
   output logic            ovf_we,
   output logic            busy,
   output logic            halted,
   output logic            lt_latched,
   output logic [2:0]      fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [3:0] OP_CPF  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_LDR  = 4'b0101;
   localparam logic [3:0] OP_STR  = 4'b0110;
   localparam logic [3:0] OP_STL  = 4'b0111;
   localparam logic [3:0] OP_LT   = 4'b1001;
   localparam logic [3:0] OP_I0   = 4'b1010;
   localparam logic [3:0] OP_I1   = 4'b1011;
   localparam logic [3:0] OP_I2   = 4'b1100;
   localparam logic [3:0] OP_I3   = 4'b1101;
   localparam logic [3:0] OP_HALT = 4'b1110;
   localparam logic [3:0] OP_BR   = 4'b1111;

   state_t     state, state_nxt;
   logic [8:0] ir;
   logic       sign_mode;
   logic [3:0] opc;
   logic [7:0] br_off;
   logic       alu_live;
   logic       imem_req, dmem_req, dmem_we, dmem_wsel;

   assign opc       = ir[8:5];
   assign br_off    = {{3{ir[4]}}, ir[4:0]};
   assign rf_ra     = ir[4:2];
   assign rf_rb     = {1'b0, ir[1:0]};
   assign alu_imm   = {3'b000, ir[4:0]};
   assign alu_sign  = sign_mode;
   assign busy      = (state != S_IDLE) && (state != S_HALT);
   assign halted    = (state == S_HALT);
   assign fsm_state = state;

   assign bus.imem_req  = imem_req;
   assign bus.dmem_req  = dmem_req;
   assign bus.dmem_we   = dmem_we;
   assign bus.dmem_wsel = dmem_wsel;

   // The ALU stays driven through WB so the result and overflow are valid at writeback.
   assign alu_live = ((state == S_EXEC) || (state == S_WB)) && (opc != OP_HALT) && (opc != OP_BR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc         <= PC_RESET;
         ir         <= '0;
         lt_latched <= 1'b0;
         sign_mode  <= SIGN_MODE_DEF;
      end else begin
         if (state == S_FETCH && bus.imem_ack) ir <= bus.instr_in;
         if (state == S_DECODE && opc != OP_HALT && opc != OP_BR) pc <= pc + 8'd1;
         if (state == S_EXEC) begin
            if (opc == OP_LT)  lt_latched <= alu_lt;
            if (opc == OP_CPF) sign_mode  <= ~sign_mode;
            // Branch target is relative to the branch's own address; PC was not advanced in DECODE.
            if (opc == OP_BR)  pc <= lt_latched ? (pc + br_off) : (pc + 8'd1);
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_wsel  = 1'b0;
      rf_we      = 1'b0;
      ovf_we     = 1'b0;
      alu_opcode = 4'b0000;
      alu_b_imm  = 1'b0;
      if (alu_live) begin
         alu_opcode = opc;
         alu_b_imm  = (opc == OP_I0) || (opc == OP_I1) || (opc == OP_I2) || (opc == OP_I3);
      end
      case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ack) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = (opc == OP_HALT) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (opc == OP_LT || opc == OP_BR)                         state_nxt = S_FETCH;
            else if (opc == OP_LDR || opc == OP_STR || opc == OP_STL) state_nxt = S_MEM;
            else                                                      state_nxt = S_WB;
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = (opc == OP_STR) || (opc == OP_STL);
            dmem_wsel = (opc == OP_STL);
            if (bus.dmem_ack) state_nxt = (opc == OP_LDR) ? S_WB : S_FETCH;
         end
         S_WB: begin
            rf_we     = 1'b1;
            ovf_we    = alu_ovf && ((opc == OP_ADD) || (opc == OP_I0) || (opc == OP_I1) || (opc == OP_I2));
            state_nxt = S_FETCH;
         end
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer: an instruction-level timeline model predicts every cycle's outputs.
module tb_alu_sequencer;

   localparam logic [7:0] PC_RST   = 8'h00;
   localparam logic       SIGN_DEF = 1'b0;

   typedef struct packed {
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       dmem_wsel;
      logic       rf_we;
      logic       ovf_we;
      logic       busy;
      logic       halted;
      logic       lt;
      logic       sign;
      logic       b_imm;
      logic [3:0] opc;
      logic [7:0] imm;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] pc;
   } obs_t;

   localparam int W = $bits(obs_t);

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] pc;
   logic [3:0] alu_opcode;
   logic       alu_sign;
   logic       alu_b_imm;
   logic [7:0] alu_imm;
   logic       alu_lt;
   logic       alu_ovf;
   logic [2:0] rf_ra;
   logic [2:0] rf_rb;
   logic       rf_we;
   logic       ovf_we;
   logic       busy;
   logic       halted;
   logic       lt_latched;
   logic [2:0] fsm_state;

   alu_sequencer_if bus_if ();

   alu_sequencer #(.PC_RESET(PC_RST), .SIGN_MODE_DEF(SIGN_DEF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bus        (bus_if.master),
      .pc         (pc),
      .alu_opcode (alu_opcode),
      .alu_sign   (alu_sign),
      .alu_b_imm  (alu_b_imm),
      .alu_imm    (alu_imm),
      .alu_lt     (alu_lt),
      .alu_ovf    (alu_ovf),
      .rf_ra      (rf_ra),
      .rf_rb      (rf_rb),
      .rf_we      (rf_we),
      .ovf_we     (ovf_we),
      .busy       (busy),
      .halted     (halted),
      .lt_latched (lt_latched),
      .fsm_state  (fsm_state)
   );

   // Clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   string        tag_q[$];
   int           n_total = 0;
   int           n_pass  = 0;

   // Architectural model
   logic [7:0] m_pc;
   logic       m_lt;
   logic       m_sign;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [8:0] junk();
      return 9'($urandom);
   endfunction

   function automatic obs_t base_obs(input logic [7:0] p, input logic b, input logic h);
      obs_t o;
      o        = '0;
      o.busy   = b;
      o.halted = h;
      o.lt     = m_lt;
      o.sign   = m_sign;
      o.pc     = p;
      return o;
   endfunction

   function automatic obs_t base_mask();
      obs_t o;
      o       = '1;
      o.opc   = '0;
      o.b_imm = 1'b0;
      o.imm   = '0;
      o.ra    = '0;
      o.rb    = '0;
      return o;
   endfunction

   // Driver: apply one cycle of inputs and queue the outputs expected during that cycle.
   task automatic step(input obs_t e, input obs_t m, input string tag, input logic ia,
                       input logic [8:0] ins, input logic da, input logic lt, input logic ovf,
                       input logic st, input logic rn);
      start           = st;
      rst_n           = rn;
      bus_if.imem_ack = ia;
      bus_if.instr_in = ins;
      bus_if.dmem_ack = da;
      alu_lt          = lt;
      alu_ovf         = ovf;
      exp_q.push_back(e);
      msk_q.push_back(m);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step(input logic st);
      obs_t e, m;
      e       = base_obs(m_pc, 1'b0, 1'b0);
      m       = base_mask();
      m.opc   = '1;
      m.b_imm = 1'b1;
      m.imm   = '1;
      step(e, m, "idle", rbit(), junk(), rbit(), rbit(), rbit(), st, 1'b1);
   endtask

   task automatic halt_step();
      obs_t e, m;
      e = base_obs(m_pc, 1'b0, 1'b1);
      m = base_mask();
      step(e, m, "halt", rbit(), junk(), rbit(), rbit(), rbit(), 1'b1, 1'b1);
   endtask

   // One instruction from fetch to its last cycle, with iw fetch and dw memory wait cycles.
   task automatic run_instr(input logic [8:0] ins, input int iw, input int dw,
                            input logic lt_in, input logic ovf_in, input bit abort);
      logic [3:0] op;
      logic [7:0] p;
      obs_t       e, m;
      op = ins[8:5];
      p  = m_pc;
      for (int i = 0; i <= iw; i++) begin
         e = base_obs(p, 1'b1, 1'b0);
         e.imem_req = 1'b1;
         m = base_mask();
         step(e, m, "fetch", 1'(i == iw), (i == iw) ? ins : junk(), rbit(), rbit(), rbit(), rbit(), 1'b1);
      end
      e    = base_obs(p, 1'b1, 1'b0);
      e.ra = ins[4:2];
      e.rb = {1'b0, ins[1:0]};
      m    = base_mask();
      m.ra = '1;
      m.rb = '1;
      step(e, m, "decode", rbit(), junk(), rbit(), rbit(), rbit(), rbit(), 1'b1);
      if (op == 4'hE) return;

      e = base_obs((op == 4'hF) ? p : p + 8'd1, 1'b1, 1'b0);
      m = base_mask();
      if (op != 4'hF) begin
         e.opc   = op;
         e.b_imm = (op >= 4'hA);
         e.imm   = {3'b000, ins[4:0]};
         m.opc   = '1;
         m.b_imm = 1'b1;
         m.imm   = '1;
      end
      step(e, m, "exec", rbit(), junk(), rbit(), (op == 4'h9) ? lt_in : rbit(), rbit(), rbit(), 1'b1);
      if (op == 4'h9) m_lt = lt_in;
      if (op == 4'h1) m_sign = ~m_sign;
      if (op == 4'hF) begin
         m_pc = m_lt ? 8'(int'(p) + int'($signed(ins[4:0]))) : p + 8'd1;
         return;
      end
      m_pc = p + 8'd1;
      if (op == 4'h9) return;

      if (op inside {4'h5, 4'h6, 4'h7}) begin
         for (int i = 0; i <= dw; i++) begin
            e = base_obs(m_pc, 1'b1, 1'b0);
            e.dmem_req  = 1'b1;
            e.dmem_we   = (op != 4'h5);
            e.dmem_wsel = (op == 4'h7);
            m = base_mask();
            if (abort) begin
               step(e, m, "mem_abort", rbit(), junk(), 1'b0, rbit(), rbit(), rbit(), 1'b0);
               m_pc   = PC_RST;
               m_lt   = 1'b0;
               m_sign = SIGN_DEF;
               return;
            end
            step(e, m, "mem", rbit(), junk(), 1'(i == dw), rbit(), rbit(), rbit(), 1'b1);
         end
         if (op != 4'h5) return;
      end

      e        = base_obs(m_pc, 1'b1, 1'b0);
      e.rf_we  = 1'b1;
      e.ovf_we = ovf_in && (op inside {4'h2, 4'hA, 4'hB, 4'hC});
      e.ra     = ins[4:2];
      m        = base_mask();
      m.ra     = '1;
      step(e, m, "wb", rbit(), junk(), rbit(), rbit(), ovf_in, rbit(), 1'b1);
   endtask

   task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // Compare process
   logic [W-1:0] cmp_e, cmp_m, cmp_a;
   string        cmp_t;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cmp_e = exp_q.pop_front();
         cmp_m = msk_q.pop_front();
         cmp_t = tag_q.pop_front();
         cmp_a = {bus_if.imem_req, bus_if.dmem_req, bus_if.dmem_we, bus_if.dmem_wsel, rf_we, ovf_we,
                  busy, halted, lt_latched, alu_sign, alu_b_imm, alu_opcode, alu_imm, rf_ra, rf_rb, pc};
         n_total++;
         if ((cmp_a & cmp_m) === (cmp_e & cmp_m)) n_pass++;
         else $display("FAIL %s @%0t: got %h expected %h (mask %h)", cmp_t, $time,
                       cmp_a & cmp_m, cmp_e & cmp_m, cmp_m);
      end
   end

   initial begin
      rst_n           = 1'b0;
      start           = 1'b0;
      bus_if.imem_ack = 1'b0;
      bus_if.instr_in = '0;
      bus_if.dmem_ack = 1'b0;
      alu_lt          = 1'b0;
      alu_ovf         = 1'b0;
      m_pc            = PC_RST;
      m_lt            = 1'b0;
      m_sign          = SIGN_DEF;
      repeat (3) @(posedge clk);
      #1;
      idle_step(1'b0);
      idle_step(1'b1);

      run_instr(9'b0010_001_10, 0, 0, 1'b0, 1'b0, 0);
      check_lit("add_pc", pc, 8'h01);
      run_instr(9'b0011_010_01, 3, 0, 1'b0, 1'b0, 0);
      check_lit("slow_fetch_pc", pc, 8'h02);
      run_instr(9'b0000_011_00, 0, 0, 1'b0, 1'b0, 0);
      run_instr(9'b0100_100_01, 1, 0, 1'b0, 1'b0, 0);
      run_instr(9'b1001_000_01, 0, 0, 1'b1, 1'b0, 0);
      check_lit("lt_latched_set", {7'd0, lt_latched}, 8'h01);
      check_lit("pre_branch_pc", pc, 8'h05);
      run_instr(9'b1111_11100, 0, 0, 1'b0, 1'b0, 0);
      check_lit("branch_taken_pc", pc, 8'h01);

      run_instr(9'b0010_001_01, 0, 0, 1'b0, 1'b0, 0);
      run_instr(9'b1000_010_10, 0, 0, 1'b0, 1'b0, 0);
      run_instr(9'b0011_011_11, 0, 0, 1'b0, 1'b0, 0);
      run_instr(9'b1001_001_10, 0, 0, 1'b0, 1'b0, 0);
      check_lit("lt_latched_clr", {7'd0, lt_latched}, 8'h00);
      run_instr(9'b1111_11100, 0, 0, 1'b0, 1'b0, 0);
      check_lit("branch_not_taken_pc", pc, 8'h06);

      run_instr(9'b1001_000_00, 0, 0, 1'b1, 1'b0, 0);
      run_instr(9'b1111_10000, 0, 0, 1'b0, 1'b0, 0);
      check_lit("branch_back_pc", pc, 8'hF7);
      run_instr(9'b1111_00111, 2, 0, 1'b0, 1'b0, 0);
      check_lit("branch_fwd_pc", pc, 8'hFE);
      run_instr(9'b1111_00101, 0, 0, 1'b0, 1'b0, 0);
      check_lit("branch_wrap_pc", pc, 8'h03);

      run_instr(9'b1100_001_01, 0, 0, 1'b0, 1'b1, 0);
      run_instr(9'b0101_010_11, 0, 2, 1'b0, 1'b1, 0);
      run_instr(9'b0111_011_00, 0, 1, 1'b0, 1'b0, 0);
      run_instr(9'b0110_100_10, 1, 0, 1'b0, 1'b1, 0);
      run_instr(9'b0001_101_00, 0, 0, 1'b0, 1'b0, 0);
      check_lit("cpf_sign", {7'd0, alu_sign}, 8'h01);

      for (int k = 0; k < 60; k++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 14));
         if (op == 4'hE) op = 4'hF;
         run_instr({op, 5'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), rbit(), 0);
      end

      run_instr(9'b0110_001_10, 0, 3, 1'b0, 1'b0, 1);
      check_lit("abort_pc", pc, PC_RST);
      check_lit("abort_busy", {7'd0, busy}, 8'h00);
      idle_step(1'b0);
      idle_step(1'b1);
      for (int k = 0; k < 10; k++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 13));
         run_instr({op, 5'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 2), rbit(), rbit(), 0);
      end
      run_instr(9'b1110_00000, 0, 0, 1'b0, 1'b0, 0);
      repeat (4) halt_step();
      check_lit("halted", {7'd0, halted}, 8'h01);
      check_lit("halt_busy", {7'd0, busy}, 8'h00);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
